// File: rtl/top_if_mult.sv
// rtl/top_if_mult.sv - pipelined multiplier with valid tracking; `TOP_IF_MULT_SIGNED_EN selects signed operands
// Data in each stage only advances alongside a valid bit, so c keeps the last product while bubbles pass.
module top_if_mult #(
  parameter int A_W     = 4,
  parameter int B_W     = 4,
  parameter int LATENCY = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               in_valid,
  input  logic [A_W-1:0]     a,
  input  logic [B_W-1:0]     b,
  output logic [A_W+B_W-1:0] c,
  output logic               out_valid
);
  localparam int P_W = A_W + B_W;

  generate
    if (LATENCY < 1 || LATENCY > 8) begin : g_bad_latency
      $error("top_if_mult: LATENCY must be in 1..8");
    end
  endgenerate

  logic [P_W-1:0] w_prod;

`ifdef TOP_IF_MULT_SIGNED_EN
  // Sign-extend to the full product width; the low P_W bits are the exact signed product.
  assign w_prod = $signed({{B_W{a[A_W-1]}}, a}) * $signed({{A_W{b[B_W-1]}}, b});
`else
  assign w_prod = {{B_W{1'b0}}, a} * {{A_W{1'b0}}, b};
`endif

  logic [P_W-1:0]     r_data [LATENCY];
  logic [LATENCY-1:0] r_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
      for (int i = 0; i < LATENCY; i++) r_data[i] <= '0;
    end else if (en) begin
      r_vld[0] <= in_valid;
      if (in_valid) r_data[0] <= w_prod;
      for (int i = 1; i < LATENCY; i++) begin
        r_vld[i] <= r_vld[i-1];
        if (r_vld[i-1]) r_data[i] <= r_data[i-1];
      end
    end
  end

  assign c         = r_data[LATENCY-1];
  assign out_valid = r_vld[LATENCY-1];

endmodule

// File: tb/tb_top_if_mult.sv
// tb/tb_top_if_mult.sv - scoreboard bench driving LATENCY=1,2,3 instances with shared directed stimulus
module tb_top_if_mult;
  localparam int N = 3;

`ifdef TOP_IF_MULT_SIGNED_EN
  localparam logic [7:0] E_FF = 8'h01;
  localparam logic [7:0] E_99 = 8'h31;
  localparam logic [7:0] E_F2 = 8'hFE;
`else
  localparam logic [7:0] E_FF = 8'hE1;
  localparam logic [7:0] E_99 = 8'h51;
  localparam logic [7:0] E_F2 = 8'h1E;
`endif

  typedef struct {
    logic [7:0] p;
    int         due;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] a = '0;
  logic [3:0] b = '0;
  logic [7:0] c_w [N];
  logic       ov_w [N];

  exp_t       q [N][$];
  logic [7:0] last_c [N];
  int         adv_cnt = 0;
  logic       last_adv = 1'b0;
  int         errors = 0;
  int         checks = 0;
  logic       done = 1'b0;

  always #5 clk = ~clk;

  top_if_mult #(.A_W(4), .B_W(4), .LATENCY(1)) u_l1 (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .a(a), .b(b),
    .c(c_w[0]), .out_valid(ov_w[0]));
  top_if_mult #(.A_W(4), .B_W(4), .LATENCY(2)) u_l2 (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .a(a), .b(b),
    .c(c_w[1]), .out_valid(ov_w[1]));
  top_if_mult #(.A_W(4), .B_W(4), .LATENCY(3)) u_l3 (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .a(a), .b(b),
    .c(c_w[2]), .out_valid(ov_w[2]));

  task automatic check(input string name, input int lat, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s L=%0d: got %0h want %0h (adv=%0d)", name, lat, got, want, adv_cnt);
    end
  endtask

  task automatic step(input logic e, input logic v, input logic [3:0] xa, input logic [3:0] xb,
                      input logic [7:0] exp_p);
    @(negedge clk);
    en = e; in_valid = v; a = xa; b = xb;
    if (e && v)
      for (int i = 0; i < N; i++) q[i].push_back('{p: exp_p, due: adv_cnt + i + 1});
    @(posedge clk);
    if (e) adv_cnt++;
    last_adv = e;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b1, 1'b0, 4'h0, 4'h0, 8'h00);
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    for (int i = 0; i < N; i++) begin
      check("rst_c", i + 1, {24'h0, c_w[i]}, 32'h0);
      check("rst_valid", i + 1, {31'h0, ov_w[i]}, 32'h0);
      q[i].delete();
      last_c[i] = 8'h00;
    end
    en = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    last_adv = 1'b0;
  endtask

  // Monitor: on each falling edge after an advancing edge, match out_valid against the queue head.
  always @(negedge clk) begin
    if (rst_n && !done) begin
      for (int i = 0; i < N; i++) begin
        if (!last_adv) begin
          check("stall_hold_c", i + 1, {24'h0, c_w[i]}, {24'h0, last_c[i]});
        end else if (ov_w[i]) begin
          if (q[i].size() == 0) begin
            check("unexpected_valid", i + 1, 32'h1, 32'h0);
          end else begin
            exp_t e;
            e = q[i].pop_front();
            check("product", i + 1, {24'h0, c_w[i]}, {24'h0, e.p});
            check("latency", i + 1, adv_cnt, e.due);
            last_c[i] = e.p;
          end
        end else begin
          check("bubble_hold_c", i + 1, {24'h0, c_w[i]}, {24'h0, last_c[i]});
          if (q[i].size() != 0 && q[i][0].due <= adv_cnt) begin
            check("missing_valid", i + 1, 32'h0, 32'h1);
            void'(q[i].pop_front());
          end
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < N; i++) last_c[i] = 8'h00;
    #12;
    for (int i = 0; i < N; i++) begin
      check("init_c", i + 1, {24'h0, c_w[i]}, 32'h0);
      check("init_valid", i + 1, {31'h0, ov_w[i]}, 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    step(1'b1, 1'b1, 4'd5, 4'd5, 8'h19);
    step(1'b1, 1'b1, 4'hF, 4'hF, E_FF);
    step(1'b1, 1'b1, 4'd0, 4'd9, 8'h00);
    step(1'b1, 1'b1, 4'd7, 4'd3, 8'd21);
    idle(4);

    step(1'b1, 1'b1, 4'd6, 4'd4, 8'd24);
    idle(4);

    step(1'b1, 1'b1, 4'd2, 4'd3, 8'd6);
    step(1'b0, 1'b1, 4'd9, 4'd9, 8'h00);
    step(1'b0, 1'b0, 4'd0, 4'd0, 8'h00);
    idle(4);

    step(1'b1, 1'b1, 4'hF, 4'h0, 8'h00);
    step(1'b1, 1'b1, 4'h0, 4'hF, 8'h00);
    idle(4);

    step(1'b1, 1'b1, 4'd9, 4'd9, E_99);
    reset_pulse();
    idle(4);

    step(1'b1, 1'b1, 4'hF, 4'h2, E_F2);
    idle(4);

    @(negedge clk);
    done = 1'b1;
    for (int i = 0; i < N; i++)
      check("queue_drained", i + 1, q[i].size(), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/top_if_mult.md
# top_if_mult

Registered unsigned multiplier with a parameterizable operand width and pipeline depth. It accepts one operand pair per clock and returns the full-width product a fixed number of cycles later, together with a valid flag. It sits behind the `top_if` signal bundle (clock, a, b, c) as a datapath leaf and needs no host configuration.

## Interface
Parameters:
- `A_W`, default 4: width of operand `a`.
- `B_W`, default 4: width of operand `b`.
- `LATENCY`, default 1: number of register stages from `a`/`b` to `c`.
  - Legal range is 1..8.
  - Out-of-range values are a compile-time error.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `en`  in  1  pipeline advance enable; 0 stalls the pipeline.
- `in_valid`  in  1  `a`/`b` carry a new operand pair this cycle.
- `a`  in  `A_W`  multiplicand.
- `b`  in  `B_W`  multiplier.
- `c`  out  `A_W+B_W`  product; driven directly from a register.
- `out_valid`  out  1  `c` was updated by the most recent advancing edge.

## Operation
- `c` is the exact `A_W+B_W`-bit product. Overflow and truncation are impossible.
- The pipeline holds `LATENCY` stages. Each stage has a data register and a valid bit.
- Stage 1 input is `{in_valid, a*b}`. The last stage drives `c` and `out_valid`.
- On a rising edge with `en=1`:
  - Every valid bit shifts one stage forward.
  - Data moves forward only where the incoming valid bit is 1; otherwise that stage's data holds.
  - `c` therefore keeps the last valid product while bubbles pass through.
- On a rising edge with `en=0`: all stages, `c` and `out_valid` hold unchanged.
- `in_valid` is ignored while `en=0`. An operand pair is only accepted on an edge where both `en=1` and `in_valid=1`.
- No backpressure and no ready signal. One pair can be accepted every cycle.
- Operand values have no special cases. All combinations, including 0 and all-ones, are treated uniformly.

## Timing
- Reset (`rst_n=0`, asynchronous):
  - All data registers, `c` and `out_valid` go to 0 immediately, with no clock edge needed.
  - They stay 0 while `rst_n` is low.
- Reset released mid-operation: all in-flight products are discarded. The first accepted pair after release produces a result normally.
- Deassertion of `rst_n` is synchronized externally. The block does not resynchronize it.
- Latency: a pair accepted at advancing edge k is visible on `c` just after advancing edge k+`LATENCY`-1.
  - With `LATENCY=1`, `c` updates at the same edge that samples `a`/`b`.
  - `out_valid` is high for exactly the same interval.
- Stall cycles (`en=0`) add latency one-for-one. Results are never lost or duplicated.
- Throughput: one result per advancing cycle.
- Simultaneous `rst_n` low and a clock edge: reset wins.

## Configuration
- Macro: `TOP_IF_MULT_SIGNED_EN`.
- Defined:
  - `a` and `b` are two's-complement signed.
  - `c` is the signed `A_W+B_W`-bit product, e.g. 4'hF × 4'hF = 8'h01.
- Undefined (default): all operands and the product are unsigned, e.g. 4'hF × 4'hF = 8'hE1 (225).
- Reset values, latency and handshake are identical in both builds.

## Test plan
- Defaults, `en=1`: `a=5`, `b=5`, `in_valid=1` at edge 1 → `c=8'h19` (25) and `out_valid=1` after edge 1.
- Back-to-back pairs (15×15, 0×9, 7×3) on consecutive edges → `c` = 225, 0, 21 on consecutive cycles, with `out_valid` held high.
- `LATENCY=3`, single pair 6×4 at edge 1 with `in_valid` low afterwards:
  - `c=24` and `out_valid=1` only after edge 3.
  - `c` holds 24 with `out_valid=0` after edge 4.
- `LATENCY=3` stall: accept 2×3, drop `en` for 2 cycles, then raise it → `c=6` appears 2 cycles later than unstalled. No duplicate `out_valid` pulse.
- Reset mid-operation: `LATENCY=2`, accept 9×9, pull `rst_n` low between edges → `c=0` and `out_valid=0` immediately. No stale 81 appears after release.
- Signed build: `a=4'hF`, `b=4'h2` → `c=8'hFE`. Unsigned build, same stimulus → `c=8'h1E` (30).
